fm_sb_playback: RTL and testbench

FM_SB_PLAYBACK -- requirements
Module: fm_sb_playback

---
 rtl/fm_sb_pkg.sv | 39 +++
 rtl/fm_sb_pb_ram.sv | 53 +++++
 rtl/fm_sb_playback.sv | 141 ++++++++++++++
 tb/tb_fm_sb_playback.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_sb_pkg.sv
// ---------------------------------------------------------------------------
// fm_sb_pkg
// Shared types and constants for the FM scoreboard playback block.
//   axi_dw        : width of one AXI register lane (bits)
//   mon_dw_max    : width of the monitor-side data bus (bits)
//   pb_mode_width : width of the playback mode field
//   pb_mode_t     : playback mode encoding
//   pb_state_t    : playback FSM states
//   fm_rt         : monitor-side output word with its qualifier
// ---------------------------------------------------------------------------
package fm_sb_pkg;

  localparam int axi_dw        = 32;
  localparam int mon_dw_max    = 256;
  localparam int pb_mode_width = 2;

  typedef enum logic [pb_mode_width-1:0] {
    PB_OFF    = 2'b00,
    PB_SINGLE = 2'b01,
    PB_LOOP   = 2'b10,
    PB_RSVD   = 2'b11
  } pb_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pb_state_t;

  typedef struct packed {
    logic [mon_dw_max-1:0] fm_data;
    logic                  fm_vld;
  } fm_rt;

  // Only single-shot and loop describe an actual playback.
  function automatic logic mode_plays(input pb_mode_t m);
    return (m == PB_SINGLE) || (m == PB_LOOP);
  endfunction

endpackage

// File: rtl/fm_sb_pb_ram.sv
// ---------------------------------------------------------------------------
// fm_sb_pb_ram
// Simple dual-port playback store, 2**AW words of DW bits, written one
// axi_dw lane at a time and read with one cycle of latency (read-first).
//   clk     : clock
//   i_we    : lane write strobe
//   i_waddr : word index of the write
//   i_wlane : lane within the word (lanes beyond DW/axi_dw are dropped)
//   i_wdata : lane write data
//   i_re    : read enable
//   i_raddr : word index of the read
//   o_rdata : registered read data, valid the cycle after i_re
// ---------------------------------------------------------------------------
module fm_sb_pb_ram
  import fm_sb_pkg::*;
#(
  parameter int DW = 96,
  parameter int AW = 10,
  parameter int LW = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [LW-1:0]     i_wlane,
  input  logic [axi_dw-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DW-1:0]     o_rdata
);

  localparam int NL = DW / axi_dw;

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // NOTE: the array and its read register carry no reset so the store maps
  // onto block RAM; the playback side gates the data with its own valid.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (i_we && (i_wlane == LW'(l))) begin
        r_mem[i_waddr][l*axi_dw +: axi_dw] <= i_wdata;
      end
    end
    // NOTE: non-blocking update means a read of the word written on the same
    // edge still sees the previous contents (read-first).
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fm_sb_playback.sv
// ---------------------------------------------------------------------------
// fm_sb_playback
// Plays a stored sequence of words onto the monitor bus, either once or in a
// loop, from a lane-writable memory filled over the AXI register side.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : lane write strobe
//   wr_addr   : {word index, lane}; lane 0 is bits 31:0
//   wr_data   : lane write data
//   pb_mode   : 00 off, 01 single-shot, 10 loop, 11 reserved
//   pb_start  : start pulse (honoured only from idle with a playing mode)
//   pb_last   : index of the last word, sampled at start
//   pb_busy   : playback in progress, up to the last valid output word
//   pb_done   : one-cycle pulse after the last single-shot word
//   pb_count  : saturating count of emitted words
//   fm_out    : registered playback word (zero-extended) and its valid
// ---------------------------------------------------------------------------
module fm_sb_playback
  import fm_sb_pkg::*;
#(
  parameter int DW = 96,
  parameter int AW = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [AW+((DW/axi_dw > 1) ? $clog2(DW/axi_dw) : 1)-1:0] wr_addr,
  input  logic [axi_dw-1:0]                 wr_data,
  input  logic [pb_mode_width-1:0]          pb_mode,
  input  logic                              pb_start,
  input  logic [AW-1:0]                     pb_last,
  output logic                              pb_busy,
  output logic                              pb_done,
  output logic [31:0]                       pb_count,
  output fm_rt                              fm_out
);

  localparam int NL = DW / axi_dw;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;

  pb_state_t r_state, w_state_nxt;
  pb_mode_t  r_mode_q;
  pb_mode_t  w_live_mode;
  logic [AW-1:0] r_idx, r_last;
  logic          w_start, w_issue, w_issue_last;
  logic          r_rd_vld, r_rd_last;
  logic          r_fm_vld, r_fm_last;
  logic [mon_dw_max-1:0] r_fm_data;
  logic          r_pb_done, r_pb_busy;
  logic [31:0]   r_pb_count;
  logic [DW-1:0] w_rd_data;

  assign w_live_mode = pb_mode_t'(pb_mode);

  fm_sb_pb_ram #(.DW(DW), .AW(AW), .LW(LW)) u_ram (
    .clk     (clk),
    .i_we    (wr_en),
    .i_waddr (wr_addr[AW+LW-1:LW]),
    .i_wlane (wr_addr[LW-1:0]),
    .i_wdata (wr_data),
    .i_re    (w_issue),
    .i_raddr (r_idx),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A live mode of off/reserved in RUN aborts before the next read is issued;
  // swaps between single-shot and loop are ignored because r_mode_q governs.
  always_comb begin
    // NOTE: every output gets a default first so no branch infers a latch.
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pb_start && mode_plays(w_live_mode)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!mode_plays(w_live_mode)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_issue = 1'b1;
          if ((r_mode_q == PB_SINGLE) && (r_idx == r_last)) begin
            w_issue_last = 1'b1;
            w_state_nxt  = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Pipeline: issue (address) -> RAM register -> output register -> done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_last     <= '0;
      r_mode_q   <= PB_OFF;
      r_rd_vld   <= 1'b0;
      r_rd_last  <= 1'b0;
      r_fm_vld   <= 1'b0;
      r_fm_last  <= 1'b0;
      r_fm_data  <= '0;
      r_pb_done  <= 1'b0;
      r_pb_busy  <= 1'b0;
      r_pb_count <= '0;
    end else begin
      if (w_start) begin
        r_idx    <= '0;
        r_last   <= pb_last;
        r_mode_q <= w_live_mode;
      end else if (w_issue) begin
        r_idx <= (r_idx == r_last) ? '0 : r_idx + AW'(1);
      end
      r_rd_vld  <= w_issue;
      r_rd_last <= w_issue_last;
      r_fm_vld  <= r_rd_vld;
      r_fm_last <= r_rd_last;
      r_fm_data <= r_rd_vld ? mon_dw_max'(w_rd_data) : '0;
      r_pb_done <= r_fm_vld && r_fm_last;
      // Busy covers words still in flight after the FSM has gone idle.
      r_pb_busy <= w_issue || r_rd_vld;
      if (r_rd_vld && (r_pb_count != 32'hFFFF_FFFF)) begin
        r_pb_count <= r_pb_count + 32'd1;
      end
    end
  end

  assign pb_busy        = r_pb_busy;
  assign pb_done        = r_pb_done;
  assign pb_count       = r_pb_count;
  assign fm_out.fm_data = r_fm_data;
  assign fm_out.fm_vld  = r_fm_vld;

endmodule

// File: tb/tb_fm_sb_playback.sv
// ---------------------------------------------------------------------------
// tb_fm_sb_playback
// Self-checking bench for fm_sb_playback (DW=96, AW=4): directed scenarios
// with literal expectations, then randomized traffic, all compared every
// cycle against a behavioural model of playback.
// ---------------------------------------------------------------------------
module tb_fm_sb_playback;
  import fm_sb_pkg::*;

  localparam int DW = 96;
  localparam int AW = 4;
  localparam int LW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW+LW-1:0] wr_addr = '0;
  logic [31:0]      wr_data = '0;
  logic [1:0]       pb_mode = 2'b00;
  logic             pb_start = 1'b0;
  logic [AW-1:0]    pb_last = '0;
  logic             pb_busy, pb_done;
  logic [31:0]      pb_count;
  fm_rt             fm_out;

  always #5 clk = ~clk;

  fm_sb_playback #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pb_mode  (pb_mode),
    .pb_start (pb_start),
    .pb_last  (pb_last),
    .pb_busy  (pb_busy),
    .pb_done  (pb_done),
    .pb_count (pb_count),
    .fm_out   (fm_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each edge: the word read on the previous edge is presented, then the
  // playback decides which word (if any) it reads now, then the memory write
  // lands (so a same-edge read sees the old word).
  logic [DW-1:0]  m_mem [2**AW];
  logic           m_playing = 1'b0;
  logic [1:0]     m_mode_q = 2'b00;
  logic [AW-1:0]  m_idx = '0, m_last = '0;
  logic           iss_vld = 1'b0, iss_last = 1'b0;
  logic [DW-1:0]  iss_data = '0;
  logic           m_vld = 1'b0, m_vld_last = 1'b0, m_done = 1'b0, m_busy = 1'b0;
  logic [255:0]   m_data = '0;
  logic [31:0]    m_count = '0;
  int             sat_req = 0, sat_seen = 0;

  always @(posedge clk or posedge rst) begin
    logic stop;
    if (rst) begin
      m_playing = 1'b0; m_mode_q = 2'b00; m_idx = '0; m_last = '0;
      iss_vld = 1'b0; iss_last = 1'b0;
      m_vld = 1'b0; m_vld_last = 1'b0; m_done = 1'b0; m_busy = 1'b0;
      m_data = '0; m_count = '0;
    end else begin
      if (sat_req != sat_seen) begin
        m_count  = 32'hFFFF_FFFE;
        sat_seen = sat_req;
      end
      m_done     = m_vld && m_vld_last;
      m_vld      = iss_vld;
      m_vld_last = iss_last;
      m_data     = iss_vld ? 256'(iss_data) : 256'd0;
      if (m_vld && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
      stop     = (pb_mode == 2'b00) || (pb_mode == 2'b11);
      iss_vld  = 1'b0;
      iss_last = 1'b0;
      if (m_playing) begin
        if (stop) m_playing = 1'b0;
        else begin
          iss_vld  = 1'b1;
          iss_data = m_mem[m_idx];
          iss_last = (m_mode_q == 2'b01) && (m_idx == m_last);
          if (m_idx == m_last) begin
            m_idx = '0;
            if (m_mode_q == 2'b01) m_playing = 1'b0;
          end else m_idx = m_idx + 4'd1;
        end
      end else if (pb_start && !stop) begin
        m_playing = 1'b1; m_idx = '0; m_last = pb_last; m_mode_q = pb_mode;
      end
      m_busy = iss_vld || m_vld;
      if (wr_en && wr_addr[1:0] < 2'd3)
        m_mem[wr_addr[5:2]][int'(wr_addr[1:0])*32 +: 32] = wr_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("fm_vld",     256'(fm_out.fm_vld), 256'(m_vld));
      check("fm_data",    fm_out.fm_data, m_data);
      check("fm_hi_zero", 256'(fm_out.fm_data[255:96]), 256'd0);
      check("pb_done",    256'(pb_done), 256'(m_done));
      check("pb_busy",    256'(pb_busy), 256'(m_busy));
      check("pb_count",   256'(pb_count), 256'(m_count));
    end
  end

  // ---------------- directed + random stimulus ----------------
  logic [DW-1:0] cap [$];
  int            n_done = 0;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (fm_out.fm_vld) cap.push_back(fm_out.fm_data[DW-1:0]);
      if (pb_done) n_done++;
    end
  endtask

  task automatic wr_lane(input logic [3:0] w, input logic [1:0] l, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = {w, l}; wr_data = d;
    run(1);
    wr_en = 1'b0;
  endtask

  task automatic start_pb(input logic [1:0] mode, input logic [3:0] last);
    pb_mode = mode; pb_last = last; pb_start = 1'b1;
    run(1);
    pb_start = 1'b0;
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return {32'(32'h200 + i), 32'(32'h100 + i), 32'(i)};
  endfunction

  initial begin
    int  wpos, seen;
    logic found;

    // Reset state
    run(2);
    check("rst_vld",   256'(fm_out.fm_vld), 256'd0);
    check("rst_data",  fm_out.fm_data, 256'd0);
    check("rst_busy",  256'(pb_busy), 256'd0);
    check("rst_done",  256'(pb_done), 256'd0);
    check("rst_count", 256'(pb_count), 256'd0);
    rst = 1'b0;
    run(1);

    // Fill every word with {idx+0x200, idx+0x100, idx}
    for (int w = 0; w < 16; w++) begin
      wr_lane(4'(w), 2'd0, 32'(w));
      wr_lane(4'(w), 2'd1, 32'(32'h100 + w));
      wr_lane(4'(w), 2'd2, 32'(32'h200 + w));
    end

    // A: single-shot, pb_last=3, cycle-exact timing from the start edge
    cap.delete(); n_done = 0;
    start_pb(2'b01, 4'd3);
    for (int e = 0; e <= 7; e++) begin
      if (e > 0) run(1);
      check("A_vld",  256'(fm_out.fm_vld), 256'(e >= 2 && e <= 5));
      check("A_data", fm_out.fm_data, (e >= 2 && e <= 5) ? 256'(word_of(e - 2)) : 256'd0);
      check("A_done", 256'(pb_done), 256'(e == 6));
      check("A_busy", 256'(pb_busy), 256'(e >= 1 && e <= 5));
    end
    check("A_w0",    256'(cap[0]), 256'(96'h00000200_00000100_00000000));
    check("A_w3",    256'(cap[3]), 256'(96'h00000203_00000103_00000003));
    check("A_count", 256'(pb_count), 256'd4);
    check("A_ndone", 256'(n_done), 256'd1);

    // B: lane 3 does not exist in a 96-bit word
    wr_lane(4'd5, 2'd3, 32'hBADB_ADBA);
    cap.delete(); n_done = 0;
    start_pb(2'b01, 4'd5);
    run(10);
    check("B_len",   256'(cap.size()), 256'd6);
    check("B_word5", 256'(cap[5]), 256'(96'h00000205_00000105_00000005));

    // C: loop over 0..2, read-first collision on word 1, then stop
    cap.delete(); n_done = 0;
    start_pb(2'b10, 4'd2);
    run(10);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_playing && m_idx == 4'd1) found = 1'b1;
      else run(1);
    end
    check("C_coll_found", 256'(found), 256'd1);
    wpos = cap.size();
    wr_lane(4'd1, 2'd0, 32'h0000_DEAD);
    run(8);
    for (int k = 0; k < 9; k++)
      check("C_seq", 256'(cap[k][63:32]), 256'(32'h100 + (k % 3)));
    seen = 0;
    for (int k = wpos; k < cap.size(); k++) begin
      if (cap[k][63:32] == 32'h101) begin
        if (seen == 0) check("C_old", 256'(cap[k][31:0]), 256'd1);
        if (seen == 1) check("C_new", 256'(cap[k][31:0]), 256'h0000_DEAD);
        seen++;
      end
    end
    check("C_passes", 256'(seen >= 2), 256'd1);
    pb_mode = 2'b00;
    run(2);
    check("C_stop_vld",  256'(fm_out.fm_vld), 256'd0);
    check("C_stop_busy", 256'(pb_busy), 256'd0);
    run(2);
    check("C_no_done", 256'(n_done), 256'd0);

    // D: start while busy and start with reserved mode are ignored
    cap.delete(); n_done = 0;
    start_pb(2'b01, 4'd7);
    run(2);
    start_pb(2'b10, 4'd2);
    run(12);
    check("D_len",   256'(cap.size()), 256'd8);
    check("D_ndone", 256'(n_done), 256'd1);
    cap.delete();
    start_pb(2'b11, 4'd3);
    for (int i = 0; i < 4; i++) begin
      run(1);
      check("D_rsvd_busy", 256'(pb_busy), 256'd0);
    end
    check("D_rsvd_len", 256'(cap.size()), 256'd0);

    // E: reset mid-run clears outputs at once; restart needs a new start
    start_pb(2'b10, 4'd3);
    run(4);
    #2 rst = 1'b1;
    #1;
    check("E_vld",   256'(fm_out.fm_vld), 256'd0);
    check("E_data",  fm_out.fm_data, 256'd0);
    check("E_busy",  256'(pb_busy), 256'd0);
    check("E_done",  256'(pb_done), 256'd0);
    check("E_count", 256'(pb_count), 256'd0);
    run(2);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run(1);
      check("E_idle_busy", 256'(pb_busy), 256'd0);
    end
    pb_mode = 2'b00;
    run(1);

    // F: count saturation
    #2;
    sat_req++;
    force dut.r_pb_count = 32'hFFFF_FFFE;
    #1 release dut.r_pb_count;
    run(1);
    start_pb(2'b01, 4'd2);
    run(8);
    check("F_sat", 256'(pb_count), 256'(32'hFFFF_FFFF));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = 6'($urandom_range(0, 63));
      wr_data  = $urandom;
      pb_start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) pb_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)  pb_last = 4'($urandom_range(0, 15));
      run(1);
    end
    wr_en = 1'b0; pb_start = 1'b0; pb_mode = 2'b00;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
